xswitch_cfg_ctrl: RTL and testbench
===================================

XSWITCH_CFG_CTRL -- requirements
Module: xswitch_cfg_ctrl

Parameters
REQ-001 The block SHALL have parameter NPORTS, default 4, the number of switch ports programmed per sequence.
REQ-002 The block SHALL have parameter DRAIN_MAX, default 255, the maximum number of DRAIN cycles before abort.

Interface
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cfg_start  input  1  pulse from the host that requests a configuration sequence.
REQ-006 cfg_prio  input  8  priority value to program.
REQ-007 cfg_addr  input  16*NPORTS  port addresses, where port i is bits [16i+15:16i].
REQ-008 cfg_en  input  NPORTS  port enables, where bit i belongs to port i.
REQ-009 fifo_empty  input  NPORTS  per-port FIFO-empty flags from the switch.
REQ-010 cfg_busy  output  1  high whenever the state is not IDLE.
REQ-011 cfg_done  output  1  one-cycle pulse on successful completion.
REQ-012 cfg_err  output  1  one-cycle pulse on drain timeout.
REQ-013 hold  output  1  traffic hold; sources SHALL NOT assert wr_en while hold is high.
REQ-014 prio_val  output  8  priority value to the switch.
REQ-015 prio_wr  output  1  priority write strobe.
REQ-016 port_sel  output  2  port index being written.
REQ-017 port_addr  output  16  address for the selected port.
REQ-018 port_en  output  1  enable for the selected port.
REQ-019 port_wr  output  1  port-table write strobe.

Function
REQ-020 The block SHALL drive every output from a register.
REQ-021 The state machine SHALL have the states IDLE, DRAIN, PRIO, PORT, DONE and ERR.
REQ-022 In IDLE, cfg_start=1 SHALL latch cfg_prio, cfg_addr and cfg_en into shadow registers and move to DRAIN on the next edge.
REQ-023 cfg_start SHALL be ignored in every state except IDLE, and the shadow registers SHALL NOT change in those states.
REQ-024 hold SHALL be 1 in DRAIN, PRIO, PORT and DONE, and 0 in IDLE and ERR.
REQ-025 In DRAIN, when fifo_empty is all ones, the block SHALL move to PRIO and clear the drain counter.
REQ-026 In DRAIN, when fifo_empty is not all ones, the 8-bit drain counter SHALL increment each cycle.
REQ-027 In DRAIN, when the drain counter equals DRAIN_MAX and fifo_empty is not all ones, the block SHALL move to ERR.
REQ-028 When all-empty and the DRAIN_MAX condition coincide, all-empty SHALL win.
REQ-029 PRIO SHALL last exactly 1 cycle, with prio_wr=1 and prio_val equal to the shadow priority, then move to PORT.
REQ-030 PORT SHALL last exactly NPORTS cycles; in cycle k, port_wr=1, port_sel=k, port_addr=shadow address k and port_en=shadow enable k.
REQ-031 After the last PORT cycle (port_sel wraps from NPORTS-1), the block SHALL move to DONE.
REQ-032 DONE SHALL last 1 cycle with cfg_done=1, then return to IDLE.
REQ-033 ERR SHALL last 1 cycle with cfg_err=1 and no strobe asserted, then return to IDLE.
REQ-034 The switch configuration SHALL remain unchanged after ERR.
REQ-035 Outside PRIO, prio_wr SHALL be 0 and prio_val SHALL be 0.
REQ-036 Outside PORT, port_wr, port_sel, port_addr and port_en SHALL all be 0.
REQ-037 prio_wr and port_wr SHALL never be high in the same cycle.
REQ-038 prio_wr SHALL be high for exactly one cycle per successful sequence.
REQ-039 port_wr SHALL be high for exactly NPORTS cycles per successful sequence.
REQ-040 With fifo_empty all ones on entry to DRAIN, cfg_done SHALL rise 7 cycles after the cfg_start sample edge (NPORTS=4).

Reset
REQ-041 reset=0 SHALL immediately force state IDLE, clear the drain counter, port index and shadow registers, and drive all outputs to 0.
REQ-042 A reset during any state SHALL abort the sequence with no cfg_done or cfg_err pulse, and no write strobe on the following cycle.
REQ-043 After reset rises, the first cfg_start SHALL be accepted on the first clk edge.

Verification
REQ-044 Nominal: fifo_empty=4'b1111, cfg_prio=8'hA5, cfg_addr=64'h0004_0003_0002_0001, cfg_en=4'b1011, start pulse -> prio_wr with prio_val A5 at cycle 2; port_wr at cycles 3-6 with (sel,addr,en) = (0,0001,1), (1,0002,1), (2,0003,0), (3,0004,1); cfg_done at cycle 7; hold in cycles 1-7.
REQ-045 Drain wait: fifo_empty=4'b1110 for 10 cycles, then 4'b1111 -> prio_wr 1 cycle after all-empty is seen; cfg_err never asserts.
REQ-046 Timeout: fifo_empty held at 4'b0111 -> cfg_err pulse after DRAIN_MAX+1 DRAIN cycles; zero prio_wr/port_wr strobes; hold drops with ERR.
REQ-047 Busy ignore: second cfg_start with different data during PORT -> programmed values are the first sequence's; only one cfg_done.
REQ-048 Reset mid-PORT: reset=0 while port_sel=2 -> all outputs 0 at once; no cfg_done; a fresh start after release completes normally.
REQ-049 Boundary: all-empty in the same cycle the counter reaches DRAIN_MAX -> move to PRIO, not ERR.

Source files
------------

// File: rtl/xswitch_cfg_ctrl.sv
// xswitch_cfg_ctrl: sequences a switch reconfiguration.
// Holds traffic, waits for every port FIFO to drain, writes the priority
// register once, then writes one port-table entry per port. A drain that
// never completes aborts to ERR without touching the switch configuration.
//
// Host protocol: cfg_start is a single-cycle request pulse. It is sampled
// only in IDLE, where it captures cfg_prio/cfg_addr/cfg_en into the shadow
// registers. While cfg_busy is high, cfg_start is ignored. Each accepted
// request ends with exactly one cfg_done or cfg_err pulse, unless a reset
// aborts it first.
//
// All outputs are registered. They are computed from the next state, so
// each output lines up with the state it belongs to.
module xswitch_cfg_ctrl #(
  parameter int NPORTS    = 4,
  parameter int DRAIN_MAX = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [7:0]             cfg_prio,
  input  logic [16*NPORTS-1:0]   cfg_addr,
  input  logic [NPORTS-1:0]      cfg_en,
  input  logic [NPORTS-1:0]      fifo_empty,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   hold,
  output logic [7:0]             prio_val,
  output logic                   prio_wr,
  output logic [1:0]             port_sel,
  output logic [15:0]            port_addr,
  output logic                   port_en,
  output logic                   port_wr,
  output logic [2:0]             state_dbg
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_PRIO  = 3'd2,
    S_PORT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                state, state_d;
  logic [7:0]            drain_cnt, drain_cnt_d;
  logic [IW-1:0]         idx, idx_d;
  logic [7:0]            sh_prio, sh_prio_d;
  logic [16*NPORTS-1:0]  sh_addr, sh_addr_d;
  logic [NPORTS-1:0]     sh_en, sh_en_d;

  logic                  busy_d, done_d, err_d, hold_d, prio_wr_d;
  logic                  port_en_d, port_wr_d;
  logic [7:0]            prio_val_d;
  logic [1:0]            port_sel_d;
  logic [15:0]           port_addr_d;
  logic                  all_empty;

  assign all_empty = &fifo_empty;

  // Next-state logic, plus the registered outputs derived from the next state.
  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    idx_d       = idx;
    sh_prio_d   = sh_prio;
    sh_addr_d   = sh_addr;
    sh_en_d     = sh_en;

    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          sh_prio_d   = cfg_prio;
          sh_addr_d   = cfg_addr;
          sh_en_d     = cfg_en;
          drain_cnt_d = 8'd0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // All-empty is tested first, so it wins over the timeout.
        if (all_empty) begin
          state_d     = S_PRIO;
          drain_cnt_d = 8'd0;
        end else if (drain_cnt == 8'(DRAIN_MAX)) begin
          state_d     = S_ERR;
          drain_cnt_d = 8'd0;
        end else begin
          drain_cnt_d = drain_cnt + 8'd1;
        end
      end
      S_PRIO: begin
        state_d = S_PORT;
        idx_d   = '0;
      end
      S_PORT: begin
        if (idx == IW'(NPORTS - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    hold_d      = (state_d == S_DRAIN) || (state_d == S_PRIO) ||
                  (state_d == S_PORT)  || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    prio_wr_d   = (state_d == S_PRIO);
    prio_val_d  = (state_d == S_PRIO) ? sh_prio : 8'd0;
    port_wr_d   = (state_d == S_PORT);
    port_sel_d  = 2'd0;
    port_addr_d = 16'd0;
    port_en_d   = 1'b0;
    if (state_d == S_PORT) begin
      port_sel_d  = 2'(idx_d);
      port_addr_d = sh_addr[{idx_d, 4'b0000} +: 16];
      port_en_d   = sh_en[idx_d];
    end
  end

  // State, counters, shadows and output registers; reset clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= 8'd0;
      idx       <= '0;
      sh_prio   <= 8'd0;
      sh_addr   <= '0;
      sh_en     <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      hold      <= 1'b0;
      prio_val  <= 8'd0;
      prio_wr   <= 1'b0;
      port_sel  <= 2'd0;
      port_addr <= 16'd0;
      port_en   <= 1'b0;
      port_wr   <= 1'b0;
      state_dbg <= 3'd0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      idx       <= idx_d;
      sh_prio   <= sh_prio_d;
      sh_addr   <= sh_addr_d;
      sh_en     <= sh_en_d;
      cfg_busy  <= busy_d;
      cfg_done  <= done_d;
      cfg_err   <= err_d;
      hold      <= hold_d;
      prio_val  <= prio_val_d;
      prio_wr   <= prio_wr_d;
      port_sel  <= port_sel_d;
      port_addr <= port_addr_d;
      port_en   <= port_en_d;
      port_wr   <= port_wr_d;
      state_dbg <= state_d;
    end
  end

endmodule

// File: tb/tb_xswitch_cfg_ctrl.sv
// Testbench for xswitch_cfg_ctrl (NPORTS=4, DRAIN_MAX=255).
// Each scenario builds the expected per-cycle output trace of a whole
// sequence from its timing rules, then drives the DUT and compares.
module tb_xswitch_cfg_ctrl;

  localparam int NPORTS    = 4;
  localparam int DRAIN_MAX = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_prio = 8'd0;
  logic [63:0] cfg_addr = 64'd0;
  logic [3:0]  cfg_en = 4'd0;
  logic [3:0]  fifo_empty = 4'hF;
  logic        cfg_busy, cfg_done, cfg_err, hold, prio_wr, port_en, port_wr;
  logic [7:0]  prio_val;
  logic [1:0]  port_sel;
  logic [15:0] port_addr;
  logic [2:0]  state_dbg;

  // Observed output vector, same packing as pack_exp().
  logic [32:0] obs;
  assign obs = {cfg_busy, cfg_done, cfg_err, hold, prio_val, prio_wr,
                port_sel, port_addr, port_en, port_wr};

  logic [32:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  xswitch_cfg_ctrl #(.NPORTS(NPORTS), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_prio(cfg_prio),
    .cfg_addr(cfg_addr), .cfg_en(cfg_en), .fifo_empty(fifo_empty),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .hold(hold),
    .prio_val(prio_val), .prio_wr(prio_wr), .port_sel(port_sel),
    .port_addr(port_addr), .port_en(port_en), .port_wr(port_wr),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [32:0] pack_exp(input logic busy, input logic done,
      input logic err, input logic hld, input logic [7:0] pv, input logic pw,
      input logic [1:0] ps, input logic [15:0] pa, input logic pe, input logic pwr);
    return {busy, done, err, hld, pv, pw, ps, pa, pe, pwr};
  endfunction

  // Reference trace, cycle 1 = first cycle after the start sample edge.
  // w = number of DRAIN cycles that see a non-empty FIFO before all-empty.
  function automatic void build_trace(input logic [7:0] p, input logic [63:0] a,
                                      input logic [3:0] e, input int w);
    logic [15:0] ak;
    exp_q.delete();
    if (w > DRAIN_MAX) begin
      for (int i = 0; i < DRAIN_MAX + 1; i++)
        exp_q.push_back(pack_exp(1, 0, 0, 1, 8'd0, 0, 2'd0, 16'd0, 0, 0));
      exp_q.push_back(pack_exp(1, 0, 1, 0, 8'd0, 0, 2'd0, 16'd0, 0, 0));
    end else begin
      for (int i = 0; i < w + 1; i++)
        exp_q.push_back(pack_exp(1, 0, 0, 1, 8'd0, 0, 2'd0, 16'd0, 0, 0));
      exp_q.push_back(pack_exp(1, 0, 0, 1, p, 1, 2'd0, 16'd0, 0, 0));
      for (int k = 0; k < NPORTS; k++) begin
        ak = a[16*k +: 16];
        exp_q.push_back(pack_exp(1, 0, 0, 1, 8'd0, 0, 2'(k), ak, e[k], 1));
      end
      exp_q.push_back(pack_exp(1, 1, 0, 1, 8'd0, 0, 2'd0, 16'd0, 0, 0));
    end
    exp_q.push_back('0);
    exp_q.push_back('0);
  endfunction

  function automatic logic [3:0] rand_not_empty();
    logic [3:0] v;
    v = 4'($urandom);
    if (v == 4'hF) v[$urandom_range(0, 3)] = 1'b0;
    return v;
  endfunction

  // Driver: one start pulse, then cycle-by-cycle drive of fifo_empty and
  // compare. restart_at injects a second start; rst_at asserts reset.
  task automatic run_seq(input string name, input logic [7:0] p,
      input logic [63:0] a, input logic [3:0] e, input int w,
      input logic [3:0] busy_pat, input int restart_at, input int rst_at);
    logic [32:0] exp;
    int c;
    build_trace(p, a, e, w);
    cfg_prio = p; cfg_addr = a; cfg_en = e; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_prio = 8'($urandom);
    cfg_addr = {$urandom, $urandom};
    cfg_en = 4'($urandom);
    c = 1;
    fifo_empty = (c <= w) ? busy_pat : 4'hF;
    while (exp_q.size() > 0) begin
      if (c == restart_at) begin
        cfg_start = 1'b1; cfg_prio = ~p; cfg_addr = ~a; cfg_en = ~e;
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
      end
      if (c == rst_at) begin
        #2 reset = 1'b0;
        #1 n_checks++;
        if (obs !== 33'd0) begin
          n_errors++;
          $display("FAIL %s async_reset: got %h expected 0", name, obs);
        end
        exp_q.delete();
        break;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
      c++;
      fifo_empty = (c <= w) ? busy_pat : 4'hF;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cfg_start = 1'b1; cfg_prio = 8'hFF; cfg_addr = '1; cfg_en = '1;
    repeat (2) @(posedge clk);
    #1 n_checks++;
    if (obs !== 33'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    cfg_start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 33'd0) begin
      n_errors++;
      $display("FAIL reset_idle_after_release: got %h expected 0", obs);
    end
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_seq("nominal", 8'hA5, 64'h0004_0003_0002_0001, 4'b1011, 0, 4'hF, -1, -1);
  endtask

  task automatic test_drain_wait();
    run_seq("drain_wait", 8'h3C, {$urandom, $urandom}, 4'($urandom), 10, 4'b1110, -1, -1);
  endtask

  task automatic test_timeout();
    run_seq("timeout", 8'h77, {$urandom, $urandom}, 4'($urandom), DRAIN_MAX + 5, 4'b0111, -1, -1);
  endtask

  task automatic test_boundary();
    run_seq("boundary_empty", 8'h5A, {$urandom, $urandom}, 4'($urandom), DRAIN_MAX, rand_not_empty(), -1, -1);
    run_seq("boundary_timeout", 8'h5B, {$urandom, $urandom}, 4'($urandom), DRAIN_MAX + 1, rand_not_empty(), -1, -1);
  endtask

  task automatic test_busy_ignore();
    run_seq("busy_ignore", 8'hC3, 64'h1111_2222_3333_4444, 4'b0110, 2, 4'b1101, 5, -1);
  endtask

  task automatic test_reset_mid_port();
    // Cycle 5 of a w=0 sequence is PORT with port_sel=2.
    run_seq("reset_mid_port", 8'h99, 64'hDEAD_BEEF_CAFE_F00D, 4'b1111, 0, 4'hF, -1, 5);
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 33'd0) begin
      n_errors++;
      $display("FAIL reset_mid_port_next_cycle: got %h expected 0", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    run_seq("after_reset", 8'h42, {$urandom, $urandom}, 4'($urandom), 0, 4'hF, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_seq("random", 8'($urandom), {$urandom, $urandom}, 4'($urandom),
              $urandom_range(0, 12), rand_not_empty(), -1, -1);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_drain_wait();
    test_timeout();
    test_boundary();
    test_busy_ignore();
    test_reset_mid_port();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
